ifu_mem_req_queue: RTL

Memory-side request queue for the IFU, sitting directly downstream of the IFU cache and prefetcher, between them and instruction memory. It merges demand-miss and prefetch tag requests into one outstanding-request table of DEPTH entries. It issues requests to memory with a valid/ready handshake, giving misses priority. It matches memory responses back to table entries and returns a registered fill to the cache, tagged as miss or prefetch.

---
 rtl/ifu_pkg.sv | 20 ++
 rtl/ifu_mem_req_sel.sv | 29 ++
 rtl/ifu_mem_req_queue.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/ifu_pkg.sv
// rtl/ifu_pkg.sv - shared types and defaults for the IFU memory request queue
// Purpose: outstanding-request entry layout, default sizing and the VALID constant.
// Ports: none (package).
package ifu_pkg;

    localparam int IFU_TAG_WIDTH  = 28;
    localparam int IFU_LINE_WIDTH = 128;
    localparam int IFU_DEPTH      = 4;

    localparam logic VALID = 1'b1;

    // Tag field is sized by IFU_TAG_WIDTH; the queue's TAG_WIDTH must match it.
    typedef struct packed {
        logic                     valid;
        logic [IFU_TAG_WIDTH-1:0] tag;
        logic                     is_pref;
        logic                     issued;
    } t_req_entry;

endpackage

// File: rtl/ifu_mem_req_sel.sv
// rtl/ifu_mem_req_sel.sv - lowest-set-bit priority selector
// Purpose: returns the index of the lowest set request bit and whether any bit is set.
// Ports:
//   req_i   [N-1:0]          candidate bit vector
//   found_o                  at least one bit set
//   idx_o   [$clog2(N)-1:0]  index of lowest set bit (0 when none)
module ifu_mem_req_sel #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req_i,
    output logic                 found_o,
    output logic [$clog2(N)-1:0] idx_o
);

    localparam int IW = $clog2(N);

    // Scan high to low so the last hit written is the lowest index.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                found_o = 1'b1;
                idx_o   = IW'(i);
            end
        end
    end

endmodule

// File: rtl/ifu_mem_req_queue.sv
// rtl/ifu_mem_req_queue.sv - IFU miss/prefetch request table toward instruction memory
// Purpose: merges demand-miss and prefetch tag requests into one outstanding table,
// issues them to memory (misses first), and returns registered fills on response.
// Ports:
//   Clock, Rst                            clock, synchronous active-low reset
//   miss_req{ValidIn,TagIn,ReadyOut}      demand-miss request handshake
//   pref_req{ValidIn,TagIn,ReadyOut}      prefetch request handshake
//   mem_req{ValidOut,TagOut,ReadyIn}      request issue to memory
//   mem_rsp{ValidIn,TagIn,InsLineIn}      memory response
//   fill_rsp{ValidOut,TagOut,InsLineOut,IsPrefOut}  registered fill to cache
//   outstandingCountOut                   number of valid entries
//   errUnmatchedRspOut                    sticky unmatched-response flag
module ifu_mem_req_queue
    import ifu_pkg::*;
#(
    parameter int TAG_WIDTH  = IFU_TAG_WIDTH,
    parameter int LINE_WIDTH = IFU_LINE_WIDTH,
    parameter int DEPTH      = IFU_DEPTH
) (
    input  logic                    Clock,
    input  logic                    Rst,
    input  logic                    miss_reqValidIn,
    input  logic [TAG_WIDTH-1:0]    miss_reqTagIn,
    output logic                    miss_reqReadyOut,
    input  logic                    pref_reqValidIn,
    input  logic [TAG_WIDTH-1:0]    pref_reqTagIn,
    output logic                    pref_reqReadyOut,
    output logic                    mem_reqValidOut,
    output logic [TAG_WIDTH-1:0]    mem_reqTagOut,
    input  logic                    mem_reqReadyIn,
    input  logic                    mem_rspValidIn,
    input  logic [TAG_WIDTH-1:0]    mem_rspTagIn,
    input  logic [LINE_WIDTH-1:0]   mem_rspInsLineIn,
    output logic                    fill_rspValidOut,
    output logic [TAG_WIDTH-1:0]    fill_rspTagOut,
    output logic [LINE_WIDTH-1:0]   fill_rspInsLineOut,
    output logic                    fill_rspIsPrefOut,
    output logic [$clog2(DEPTH):0]  outstandingCountOut,
    output logic                    errUnmatchedRspOut
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;

    t_req_entry             entry_q [DEPTH];
    t_req_entry             entry_d [DEPTH];
    logic                   lock_valid_q, lock_valid_d;
    logic [IW-1:0]          lock_idx_q, lock_idx_d;
    logic                   fill_valid_q, fill_valid_d;
    logic [TAG_WIDTH-1:0]   fill_tag_q, fill_tag_d;
    logic [LINE_WIDTH-1:0]  fill_line_q, fill_line_d;
    logic                   fill_pref_q, fill_pref_d;
    logic                   err_q, err_d;

    logic [DEPTH-1:0] free_vec, free2_vec, miss_hit, pref_hit, rsp_hit;
    logic [DEPTH-1:0] unissued_miss, unissued_pref;
    logic [CW-1:0]    valid_cnt, free_cnt;

    always_comb begin
        valid_cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            free_vec[i]      = !entry_q[i].valid;
            miss_hit[i]      = entry_q[i].valid && (entry_q[i].tag == miss_reqTagIn);
            pref_hit[i]      = entry_q[i].valid && (entry_q[i].tag == pref_reqTagIn);
            rsp_hit[i]       = entry_q[i].valid && entry_q[i].issued && (entry_q[i].tag == mem_rspTagIn);
            unissued_miss[i] = entry_q[i].valid && !entry_q[i].issued && !entry_q[i].is_pref;
            unissued_pref[i] = entry_q[i].valid && !entry_q[i].issued && entry_q[i].is_pref;
            valid_cnt        = valid_cnt + CW'(entry_q[i].valid);
        end
        free_cnt = CW'(DEPTH) - valid_cnt;
    end

    logic          free0_found, free2_found, umiss_found, upref_found, rsp_found;
    logic [IW-1:0] free0_idx, free2_idx, umiss_idx, upref_idx, rsp_idx;

    // Second free slot: same search with the first free slot masked off.
    always_comb begin
        free2_vec            = free_vec;
        free2_vec[free0_idx] = 1'b0;
    end

    ifu_mem_req_sel #(.N(DEPTH)) u_sel_free0 (.req_i(free_vec),      .found_o(free0_found), .idx_o(free0_idx));
    ifu_mem_req_sel #(.N(DEPTH)) u_sel_free2 (.req_i(free2_vec),     .found_o(free2_found), .idx_o(free2_idx));
    ifu_mem_req_sel #(.N(DEPTH)) u_sel_miss  (.req_i(unissued_miss), .found_o(umiss_found), .idx_o(umiss_idx));
    ifu_mem_req_sel #(.N(DEPTH)) u_sel_pref  (.req_i(unissued_pref), .found_o(upref_found), .idx_o(upref_idx));
    ifu_mem_req_sel #(.N(DEPTH)) u_sel_rsp   (.req_i(rsp_hit),       .found_o(rsp_found),   .idx_o(rsp_idx));

    logic          miss_match, pref_match, miss_fire, pref_fire, miss_alloc, pref_alloc;
    logic          issue_fire, rsp_free;
    logic [IW-1:0] pref_slot, sel_idx;

    // Ready uses pre-edge occupancy: a slot freed this cycle is not reusable until next cycle.
    // The last free slot is held back for misses while a miss is competing.
    assign miss_match       = |miss_hit;
    assign pref_match       = |pref_hit;
    assign miss_reqReadyOut = miss_match || (free_cnt != '0);
    assign pref_reqReadyOut = pref_match || (free_cnt >= CW'(2)) ||
                              ((free_cnt >= CW'(1)) && !miss_reqValidIn);
    assign miss_fire        = miss_reqValidIn && miss_reqReadyOut;
    assign pref_fire        = pref_reqValidIn && pref_reqReadyOut;
    assign miss_alloc       = miss_fire && !miss_match && free0_found;
    // A prefetch carrying the same tag as an allocating miss folds into the miss entry.
    assign pref_alloc       = pref_fire && !pref_match &&
                              !(miss_alloc && (pref_reqTagIn == miss_reqTagIn)) &&
                              (miss_alloc ? free2_found : free0_found);
    assign pref_slot        = miss_alloc ? free2_idx : free0_idx;

    // A locked index keeps the presented tag stable until memory takes it.
    assign sel_idx         = lock_valid_q ? lock_idx_q : (umiss_found ? umiss_idx : upref_idx);
    assign mem_reqValidOut = lock_valid_q || umiss_found || upref_found;
    assign mem_reqTagOut   = entry_q[sel_idx].tag;
    assign issue_fire      = mem_reqValidOut && mem_reqReadyIn;
    assign rsp_free        = mem_rspValidIn && rsp_found;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entry_d[i] = entry_q[i];
            if (miss_fire && miss_hit[i]) entry_d[i].is_pref = 1'b0;
            if (issue_fire && (sel_idx == IW'(i))) entry_d[i].issued = 1'b1;
            if (rsp_free && (rsp_idx == IW'(i))) entry_d[i].valid = 1'b0;
            if (miss_alloc && (free0_idx == IW'(i))) entry_d[i] = '{VALID, miss_reqTagIn, 1'b0, 1'b0};
            if (pref_alloc && (pref_slot == IW'(i))) entry_d[i] = '{VALID, pref_reqTagIn, 1'b1, 1'b0};
        end

        lock_valid_d = lock_valid_q;
        lock_idx_d   = lock_idx_q;
        if (issue_fire) begin
            lock_valid_d = 1'b0;
        end else if (mem_reqValidOut) begin
            lock_valid_d = 1'b1;
            lock_idx_d   = sel_idx;
        end

        // An entry upgraded by a miss in its freeing cycle is reported as a demand fill.
        fill_valid_d = rsp_free;
        fill_tag_d   = fill_tag_q;
        fill_line_d  = fill_line_q;
        fill_pref_d  = fill_pref_q;
        if (rsp_free) begin
            fill_tag_d  = mem_rspTagIn;
            fill_line_d = mem_rspInsLineIn;
            fill_pref_d = entry_q[rsp_idx].is_pref && !(miss_fire && miss_hit[rsp_idx]);
        end

        err_d = err_q || (mem_rspValidIn && !rsp_found);
    end

    always_ff @(posedge Clock) begin
        if (!Rst) begin
            for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
            lock_valid_q <= 1'b0;
            lock_idx_q   <= '0;
            fill_valid_q <= 1'b0;
            fill_tag_q   <= '0;
            fill_line_q  <= '0;
            fill_pref_q  <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) entry_q[i] <= entry_d[i];
            lock_valid_q <= lock_valid_d;
            lock_idx_q   <= lock_idx_d;
            fill_valid_q <= fill_valid_d;
            fill_tag_q   <= fill_tag_d;
            fill_line_q  <= fill_line_d;
            fill_pref_q  <= fill_pref_d;
            err_q        <= err_d;
        end
    end

    assign fill_rspValidOut    = fill_valid_q;
    assign fill_rspTagOut      = fill_tag_q;
    assign fill_rspInsLineOut  = fill_line_q;
    assign fill_rspIsPrefOut   = fill_pref_q;
    assign outstandingCountOut = valid_cnt;
    assign errUnmatchedRspOut  = err_q;

endmodule
